swc_ctrl: RTL and testbench

Stopwatch/timer controller that sequences a chain of four decimal up/down digit counters (units..thousands) into a 4-digit BCD stopwatch or countdown timer. It turns start/stop/clear/lap commands into per-digit enable, reset and direction controls, generates the count tick from the system clock, detects terminal count, and provides a lap-freezable display value. It sits between the debounced button logic and the four `swc` digit instances.

---
 rtl/swc_ctrl_if.sv | 37 +++
 rtl/swc_ctrl.sv | 114 +++++++++++
 tb/tb_swc_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/swc_ctrl_if.sv
// Command, digit-feedback and control/status bundle between swc_ctrl and its surroundings.
interface swc_ctrl_if;
    // commands from button logic
    logic        swcc_start;
    logic        swcc_stop;
    logic        swcc_clear;
    logic        swcc_lap;
    logic        swcc_dir;
    // digit feedback, q0 = units
    logic [3:0]  swcc_q0;
    logic [3:0]  swcc_q1;
    logic [3:0]  swcc_q2;
    logic [3:0]  swcc_q3;
    // digit controls and status
    logic [3:0]  swcc_en;
    logic        swcc_rst_o;
    logic        swcc_sel;
    logic        swcc_dsel;
    logic [15:0] swcc_disp;
    logic        swcc_run;
    logic        swcc_done;
    logic        swcc_frz;

    modport master (
        output swcc_start, swcc_stop, swcc_clear, swcc_lap, swcc_dir,
        output swcc_q0, swcc_q1, swcc_q2, swcc_q3,
        input  swcc_en, swcc_rst_o, swcc_sel, swcc_dsel, swcc_disp,
        input  swcc_run, swcc_done, swcc_frz
    );

    modport slave (
        input  swcc_start, swcc_stop, swcc_clear, swcc_lap, swcc_dir,
        input  swcc_q0, swcc_q1, swcc_q2, swcc_q3,
        output swcc_en, swcc_rst_o, swcc_sel, swcc_dsel, swcc_disp,
        output swcc_run, swcc_done, swcc_frz
    );
endinterface

// File: rtl/swc_ctrl.sv
// Stopwatch/timer controller: sequences four BCD digit counters, generates the
// count tick, detects terminal count and provides a lap-freezable display.
module swc_ctrl #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic       swcc_clk,
    input  logic       swcc_rst_n,
    swc_ctrl_if.slave  bus
);

    localparam int unsigned PscW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(TICK_DIV - 1);

    typedef enum logic [2:0] {StClear, StIdle, StRun, StPause, StDone} state_e;

    state_e          state;
    logic            dir_r;
    logic [PscW-1:0] psc;
    logic [15:0]     lap_r;
    logic            frozen;

    logic [3:0] term;
    logic [3:0] at_t;
    logic       all_t;
    logic       tick;
    logic       lap_go;
    logic [3:0] en;

    // Tick, terminal-digit detection and the ripple enable chain.
    always_comb begin
        term    = dir_r ? 4'd9 : 4'd0;
        at_t[0] = (bus.swcc_q0 == term);
        at_t[1] = (bus.swcc_q1 == term);
        at_t[2] = (bus.swcc_q2 == term);
        at_t[3] = (bus.swcc_q3 == term);
        all_t   = &at_t;
        tick    = (state == StRun) && (psc == PscMax);
        // lap acts only when no higher-priority command shares the cycle
        lap_go  = bus.swcc_lap & ~bus.swcc_clear & ~bus.swcc_stop & ~bus.swcc_start;
        en      = 4'b0000;
        // a tick at full terminal count enables nothing, so digits never wrap
        en[0]   = tick & ~all_t;
        en[1]   = en[0] & at_t[0];
        en[2]   = en[1] & at_t[1];
        en[3]   = en[2] & at_t[2];
    end

    // Control FSM with prescaler, direction latch and lap snapshot.
    always_ff @(posedge swcc_clk or negedge swcc_rst_n) begin
        if (!swcc_rst_n) begin
            state  <= StClear;
            dir_r  <= 1'b1;
            psc    <= '0;
            lap_r  <= '0;
            frozen <= 1'b0;
        end else begin
            unique case (state)
                StClear: begin
                    dir_r  <= bus.swcc_dir;
                    frozen <= 1'b0;
                    psc    <= '0;
                    state  <= StIdle;
                end
                StIdle: begin
                    if (bus.swcc_clear)      state <= StClear;
                    else if (bus.swcc_start) state <= StRun;
                end
                StRun: begin
                    psc <= (psc == PscMax) ? '0 : psc + PscW'(1);
                    if (bus.swcc_clear)     state <= StClear;
                    else if (bus.swcc_stop) state <= StPause;
                    else if (tick && all_t) state <= StDone;
                    if (lap_go) begin
                        if (frozen) begin
                            frozen <= 1'b0;
                        end else begin
                            lap_r  <= {bus.swcc_q3, bus.swcc_q2, bus.swcc_q1, bus.swcc_q0};
                            frozen <= 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (bus.swcc_clear)      state <= StClear;
                    else if (bus.swcc_start) state <= StRun;
                end
                StDone: begin
                    if (bus.swcc_clear) begin
                        state <= StClear;
                    end else if (lap_go) begin
                        if (frozen) begin
                            frozen <= 1'b0;
                        end else begin
                            lap_r  <= {bus.swcc_q3, bus.swcc_q2, bus.swcc_q1, bus.swcc_q0};
                            frozen <= 1'b1;
                        end
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

    assign bus.swcc_en    = en;
    assign bus.swcc_rst_o = (state == StClear);
    assign bus.swcc_sel   = 1'b1;
    // During CLEAR the digits preload using the direction being latched, not the old one.
    assign bus.swcc_dsel  = (state == StClear) ? bus.swcc_dir : dir_r;
    assign bus.swcc_disp  = frozen ? lap_r
                                   : {bus.swcc_q3, bus.swcc_q2, bus.swcc_q1, bus.swcc_q0};
    assign bus.swcc_run   = (state == StRun);
    assign bus.swcc_done  = (state == StDone);
    assign bus.swcc_frz   = frozen;

endmodule

// File: tb/tb_swc_ctrl.sv
// Directed bench for swc_ctrl with a behavioural model of the four digit counters.
module tb_swc_ctrl;

    localparam int unsigned TickDiv = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  dq [4];
    logic        ld;
    logic [15:0] ld_val;
    int          total = 0;
    int          bad   = 0;

    swc_ctrl_if bus ();

    swc_ctrl #(.TICK_DIV(TickDiv)) dut (
        .swcc_clk   (clk),
        .swcc_rst_n (rst_n),
        .bus        (bus)
    );

    assign bus.swcc_q0 = dq[0];
    assign bus.swcc_q1 = dq[1];
    assign bus.swcc_q2 = dq[2];
    assign bus.swcc_q3 = dq[3];

    // Four decimal up/down digits driven by the controller, plus a bench preload.
    always_ff @(posedge clk) begin
        if (ld) begin
            dq[0] <= ld_val[3:0];
            dq[1] <= ld_val[7:4];
            dq[2] <= ld_val[11:8];
            dq[3] <= ld_val[15:12];
        end else if (bus.swcc_rst_o) begin
            for (int k = 0; k < 4; k++) dq[k] <= bus.swcc_dsel ? 4'd0 : 4'd9;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.swcc_en[k]) begin
                    if (bus.swcc_dsel) dq[k] <= (dq[k] == 4'd9) ? 4'd0 : dq[k] + 4'd1;
                    else               dq[k] <= (dq[k] == 4'd0) ? 4'd9 : dq[k] - 4'd1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at a negedge in IDLE.
    task automatic do_clear(input logic d);
        bus.swcc_dir   = d;
        bus.swcc_clear = 1'b1;
        @(negedge clk);
        bus.swcc_clear = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first RUN cycle.
    task automatic do_start();
        bus.swcc_start = 1'b1;
        @(negedge clk);
        bus.swcc_start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        ld_val = v;
        ld     = 1'b1;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.swcc_start = 1'b0; bus.swcc_stop = 1'b0; bus.swcc_clear = 1'b0;
        bus.swcc_lap = 1'b0;   bus.swcc_dir = 1'b1;
        ld = 1'b0; ld_val = 16'h0000;
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.swcc_rst_o !== 1'b1) begin bad++; $display("FAIL rst_rst_o got %b want 1", bus.swcc_rst_o); end
        total++; if (bus.swcc_en !== 4'b0000) begin bad++; $display("FAIL rst_en got %b want 0000", bus.swcc_en); end
        total++; if ({bus.swcc_run, bus.swcc_done, bus.swcc_frz} !== 3'b000) begin
            bad++; $display("FAIL rst_status got %b want 000", {bus.swcc_run, bus.swcc_done, bus.swcc_frz}); end
        total++; if ({bus.swcc_sel, bus.swcc_dsel} !== 2'b11) begin
            bad++; $display("FAIL rst_sel_dsel got %b want 11", {bus.swcc_sel, bus.swcc_dsel}); end
        cyc(2);
        total++; if (bus.swcc_disp !== 16'h0000) begin bad++; $display("FAIL rst_disp got %h want 0000", bus.swcc_disp); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.swcc_rst_o !== 1'b1) begin bad++; $display("FAIL rel_rst_o got %b want 1", bus.swcc_rst_o); end
        @(negedge clk);
        total++; if (bus.swcc_rst_o !== 1'b0) begin bad++; $display("FAIL idle_rst_o got %b want 0", bus.swcc_rst_o); end
    endtask

    task automatic test_count_up();
        int   seen = 0;
        logic exp0;
        do_start();
        for (int c = 0; c < 40; c++) begin
            exp0 = ((c % 4) == 3);
            total++; if (bus.swcc_en[0] !== exp0) begin
                bad++; $display("FAIL up_en0 c=%0d got %b want %b", c, bus.swcc_en[0], exp0); end
            if (exp0 && dq[0] == 4'd9) begin
                seen++;
                total++; if (bus.swcc_en[1] !== 1'b1) begin bad++; $display("FAIL up_en1 got %b want 1", bus.swcc_en[1]); end
            end
            @(negedge clk);
        end
        total++; if (bus.swcc_disp !== 16'h0010) begin bad++; $display("FAIL up_disp got %h want 0010", bus.swcc_disp); end
        total++; if (seen !== 1) begin bad++; $display("FAIL up_carry_ticks got %0d want 1", seen); end
    endtask

    task automatic test_terminal_up();
        do_clear(1'b1);
        do_load(16'h9998);
        total++; if (bus.swcc_disp !== 16'h9998) begin bad++; $display("FAIL term_load got %h want 9998", bus.swcc_disp); end
        do_start();
        cyc(3);
        total++; if (bus.swcc_en !== 4'b0001) begin bad++; $display("FAIL term_tick1 got %b want 0001", bus.swcc_en); end
        @(negedge clk);
        total++; if (bus.swcc_disp !== 16'h9999) begin bad++; $display("FAIL term_9999 got %h want 9999", bus.swcc_disp); end
        cyc(3);
        total++; if ({bus.swcc_en, bus.swcc_run} !== 5'b00001) begin
            bad++; $display("FAIL term_tick2 got %b want 00001", {bus.swcc_en, bus.swcc_run}); end
        @(negedge clk);
        total++; if ({bus.swcc_done, bus.swcc_run, bus.swcc_en} !== 6'b100000) begin
            bad++; $display("FAIL term_done got %b want 100000", {bus.swcc_done, bus.swcc_run, bus.swcc_en}); end
        total++; if (bus.swcc_disp !== 16'h9999) begin bad++; $display("FAIL term_hold got %h want 9999", bus.swcc_disp); end
        do_start();
        cyc(6);
        total++; if ({bus.swcc_done, bus.swcc_run, bus.swcc_disp} !== {2'b10, 16'h9999}) begin
            bad++; $display("FAIL done_ignores_start got %b %b %h want 1 0 9999",
                            bus.swcc_done, bus.swcc_run, bus.swcc_disp); end
    endtask

    task automatic test_count_down();
        bus.swcc_dir   = 1'b0;
        bus.swcc_clear = 1'b1;
        @(negedge clk);
        bus.swcc_clear = 1'b0;
        total++; if ({bus.swcc_rst_o, bus.swcc_dsel, bus.swcc_en} !== 6'b100000) begin
            bad++; $display("FAIL dn_clear got %b want 100000", {bus.swcc_rst_o, bus.swcc_dsel, bus.swcc_en}); end
        @(negedge clk);
        total++; if (bus.swcc_disp !== 16'h9999) begin bad++; $display("FAIL dn_preload got %h want 9999", bus.swcc_disp); end
        bus.swcc_dir = 1'b1;
        do_start();
        cyc(3);
        total++; if (bus.swcc_en !== 4'b0001) begin bad++; $display("FAIL dn_tick1 got %b want 0001", bus.swcc_en); end
        @(negedge clk);
        total++; if ({bus.swcc_disp, bus.swcc_dsel} !== {16'h9998, 1'b0}) begin
            bad++; $display("FAIL dn_9998 got %h dsel %b want 9998 0", bus.swcc_disp, bus.swcc_dsel); end
        cyc(32);
        total++; if (bus.swcc_disp !== 16'h9990) begin bad++; $display("FAIL dn_9990 got %h want 9990", bus.swcc_disp); end
        cyc(3);
        total++; if (bus.swcc_en !== 4'b0011) begin bad++; $display("FAIL dn_borrow got %b want 0011", bus.swcc_en); end
        @(negedge clk);
        total++; if (bus.swcc_disp !== 16'h9989) begin bad++; $display("FAIL dn_9989 got %h want 9989", bus.swcc_disp); end
        do_clear(1'b0);
        do_load(16'h0001);
        do_start();
        cyc(4);
        total++; if (bus.swcc_disp !== 16'h0000) begin bad++; $display("FAIL dn_0000 got %h want 0000", bus.swcc_disp); end
        cyc(3);
        total++; if (bus.swcc_en !== 4'b0000) begin bad++; $display("FAIL dn_term_en got %b want 0000", bus.swcc_en); end
        @(negedge clk);
        total++; if ({bus.swcc_done, bus.swcc_disp} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL dn_done got %b %h want 1 0000", bus.swcc_done, bus.swcc_disp); end
    endtask

    task automatic test_lap();
        do_clear(1'b1);
        do_start();
        cyc(20);
        total++; if (bus.swcc_disp !== 16'h0005) begin bad++; $display("FAIL lap_pre got %h want 0005", bus.swcc_disp); end
        bus.swcc_lap = 1'b1;
        @(negedge clk);
        bus.swcc_lap = 1'b0;
        total++; if ({bus.swcc_frz, bus.swcc_disp} !== {1'b1, 16'h0005}) begin
            bad++; $display("FAIL lap_freeze got %b %h want 1 0005", bus.swcc_frz, bus.swcc_disp); end
        cyc(15);
        total++; if ({dq[3], dq[2], dq[1], dq[0]} !== 16'h0009) begin
            bad++; $display("FAIL lap_live got %h want 0009", {dq[3], dq[2], dq[1], dq[0]}); end
        total++; if ({bus.swcc_frz, bus.swcc_disp} !== {1'b1, 16'h0005}) begin
            bad++; $display("FAIL lap_hold got %b %h want 1 0005", bus.swcc_frz, bus.swcc_disp); end
        bus.swcc_lap = 1'b1;
        @(negedge clk);
        bus.swcc_lap = 1'b0;
        total++; if ({bus.swcc_frz, bus.swcc_disp} !== {1'b0, 16'h0009}) begin
            bad++; $display("FAIL lap_release got %b %h want 0 0009", bus.swcc_frz, bus.swcc_disp); end
        cyc(3);
        total++; if (bus.swcc_disp !== 16'h0010) begin bad++; $display("FAIL lap_live_disp got %h want 0010", bus.swcc_disp); end
    endtask

    task automatic test_pause();
        do_clear(1'b1);
        do_start();
        cyc(6);
        total++; if (bus.swcc_disp !== 16'h0001) begin bad++; $display("FAIL pause_pre got %h want 0001", bus.swcc_disp); end
        bus.swcc_stop = 1'b1;
        @(negedge clk);
        bus.swcc_stop = 1'b0;
        total++; if (bus.swcc_run !== 1'b0) begin bad++; $display("FAIL pause_run got %b want 0", bus.swcc_run); end
        for (int i = 0; i < 20; i++) begin
            total++; if ({bus.swcc_en, bus.swcc_disp} !== {4'b0000, 16'h0001}) begin
                bad++; $display("FAIL pause_hold i=%0d got %b %h want 0000 0001", i, bus.swcc_en, bus.swcc_disp); end
            @(negedge clk);
        end
        do_start();
        total++; if ({bus.swcc_run, bus.swcc_en} !== 5'b10001) begin
            bad++; $display("FAIL resume_tick got %b want 10001", {bus.swcc_run, bus.swcc_en}); end
        @(negedge clk);
        total++; if (bus.swcc_disp !== 16'h0002) begin bad++; $display("FAIL resume_disp got %h want 0002", bus.swcc_disp); end
    endtask

    task automatic test_clear_start();
        bus.swcc_clear = 1'b1;
        bus.swcc_start = 1'b1;
        @(negedge clk);
        bus.swcc_clear = 1'b0;
        bus.swcc_start = 1'b0;
        total++; if ({bus.swcc_rst_o, bus.swcc_run} !== 2'b10) begin
            bad++; $display("FAIL cs_clear got %b want 10", {bus.swcc_rst_o, bus.swcc_run}); end
        @(negedge clk);
        total++; if ({bus.swcc_rst_o, bus.swcc_run, bus.swcc_done, bus.swcc_disp} !== {3'b000, 16'h0000}) begin
            bad++; $display("FAIL cs_idle got %b%b%b %h want 000 0000",
                            bus.swcc_rst_o, bus.swcc_run, bus.swcc_done, bus.swcc_disp); end
        cyc(4);
        total++; if (bus.swcc_run !== 1'b0) begin bad++; $display("FAIL cs_stay_idle got %b want 0", bus.swcc_run); end
    endtask

    task automatic test_async_reset();
        do_start();
        cyc(5);
        total++; if (bus.swcc_run !== 1'b1) begin bad++; $display("FAIL ar_running got %b want 1", bus.swcc_run); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.swcc_run, bus.swcc_rst_o, bus.swcc_en} !== 6'b010000) begin
            bad++; $display("FAIL ar_reset got %b want 010000", {bus.swcc_run, bus.swcc_rst_o, bus.swcc_en}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({bus.swcc_rst_o, bus.swcc_run, bus.swcc_disp} !== {2'b00, 16'h0000}) begin
            bad++; $display("FAIL ar_idle got %b%b %h want 00 0000", bus.swcc_rst_o, bus.swcc_run, bus.swcc_disp); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_terminal_up();
        test_count_down();
        test_lap();
        test_pause();
        test_clear_start();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
